// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and receive FSM state encoding
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_e;
endpackage

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_if: valid/ready byte stream from the receive deframer to its consumer
interface uart_rx_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous inputs with a configurable reset value
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 receive deframer driven by the 16x baud tick, with valid/ready output
module uart_rx_deframer #(
    parameter int DATA_BITS  = uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic      clk_50m,
    input  logic      rst_n,
    input  logic      rxclk_en,
    input  logic      rx,
    uart_rx_if.master rx_if,
    output logic      frame_err,
    output logic      overrun
);
    import uart_pkg::*;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] MID         = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_s;
    logic                 stall;

    sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // A pending byte blocks delivery only if the consumer is not taking it this very cycle
    assign stall = valid_q && !rx_if.rx_ready;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = stall;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        if (rxclk_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == MID) begin
                        state_d = rx_s ? IDLE : DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SAMPLE) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        state_d = (bit_q == LAST_BIT) ? STOP : DATA;
                    end
                end
                STOP: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d     = rx_s ? IDLE : BREAK;
                        frame_err_d = !rx_s;
                        overrun_d   = rx_s && stall;
                        data_d      = (rx_s && !stall) ? shift_q : data_q;
                        valid_d     = rx_s || stall;
                    end
                end
                BREAK: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
endmodule
